alien_fleet_controller: RTL and testbench

//  Sequences the whole alien formation: paces marching from frame ticks, detects screen edges, issues drop-and-reverse.

---
 rtl/alien_fleet_pkg.sv | 27 ++
 rtl/fleet_rr_arbiter.sv | 48 ++++
 rtl/alien_fleet_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_alien_fleet_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alien_fleet_pkg.sv
// Shared types and default geometry for the alien fleet controller.
package alien_fleet_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MARCH   = 3'd1,
        DROP    = 3'd2,
        CLEARED = 3'd3,
        LANDED  = 3'd4
    } fleet_state_e;

    localparam int unsigned DEF_NUM_COLS    = 8;
    localparam int unsigned DEF_NUM_ROWS    = 4;
    localparam logic [15:0] DEF_COL_PITCH   = 16'd24;
    localparam logic [15:0] DEF_START_X     = 16'd32;
    localparam logic [15:0] DEF_START_Y     = 16'd40;
    localparam logic [15:0] DEF_LEFT_BOUND  = 16'd8;
    localparam logic [15:0] DEF_RIGHT_BOUND = 16'd616;
    localparam logic [15:0] DEF_STEP_X      = 16'd4;
    localparam logic [15:0] DEF_STEP_Y      = 16'd8;
    localparam logic [15:0] DEF_LAND_Y      = 16'd400;
    localparam logic [15:0] DEF_BASE_PERIOD = 16'd30;
    localparam logic [15:0] DEF_MIN_PERIOD  = 16'd2;
    localparam logic [15:0] DEF_FIRE_PERIOD = 16'd45;
    localparam logic [15:0] SPRITE_W        = 16'd16;

endpackage

// File: rtl/fleet_rr_arbiter.sv
// Round-robin one-hot grant over alive aliens; the search starts just after the last granted index.
module fleet_rr_arbiter
    import alien_fleet_pkg::*;
#(
    parameter int unsigned N = DEF_NUM_COLS * DEF_NUM_ROWS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_grant
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_pos;
    logic [IW-1:0] w_idx;
    logic [N-1:0]  w_grant;
    logic          w_found;

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = r_ptr;
        w_pos   = '0;
        for (int k = 1; k <= int'(N); k++) begin
            w_pos = IW'((int'(r_ptr) + k) % int'(N));
            if (!w_found && i_req[w_pos]) begin
                w_grant[w_pos] = 1'b1;
                w_found        = 1'b1;
                w_idx          = w_pos;
            end
        end
    end

    // Pointer starts at the top index so the first search begins at alien 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IW'(N - 1);
        end else if (i_advance && w_found) begin
            r_ptr <= w_idx;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/alien_fleet_controller.sv
// Fleet sequencer: march pacing, edge detection, drop/reverse, fire grants, cleared/landed flags.
// Optional kill-based speed-up is enabled by defining ALIEN_FLEET_SPEEDUP_EN.
module alien_fleet_controller
    import alien_fleet_pkg::*;
#(
    parameter int unsigned NUM_COLS    = DEF_NUM_COLS,
    parameter int unsigned NUM_ROWS    = DEF_NUM_ROWS,
    parameter logic [15:0] COL_PITCH   = DEF_COL_PITCH,
    parameter logic [15:0] START_X     = DEF_START_X,
    parameter logic [15:0] START_Y     = DEF_START_Y,
    parameter logic [15:0] LEFT_BOUND  = DEF_LEFT_BOUND,
    parameter logic [15:0] RIGHT_BOUND = DEF_RIGHT_BOUND,
    parameter logic [15:0] STEP_X      = DEF_STEP_X,
    parameter logic [15:0] STEP_Y      = DEF_STEP_Y,
    parameter logic [15:0] LAND_Y      = DEF_LAND_Y,
    parameter logic [15:0] BASE_PERIOD = DEF_BASE_PERIOD,
    parameter logic [15:0] MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter logic [15:0] FIRE_PERIOD = DEF_FIRE_PERIOD
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic                         i_frame_tick,
    input  logic [NUM_COLS*NUM_ROWS-1:0] i_alive_mask,
    input  logic                         i_shot_busy,
    output logic                         o_move_tick,
    output logic                         o_drop_tick,
    output logic                         o_move_dir,
    output logic [15:0]                  o_fleet_x,
    output logic [15:0]                  o_fleet_y,
    output logic [NUM_COLS*NUM_ROWS-1:0] o_armed,
    output logic                         o_cleared,
    output logic                         o_landed
);

    localparam int unsigned N  = NUM_COLS * NUM_ROWS;
    localparam int unsigned CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_MARCH   = MARCH;
    localparam logic [2:0] ST_DROP    = DROP;
    localparam logic [2:0] ST_CLEARED = CLEARED;
    localparam logic [2:0] ST_LANDED  = LANDED;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
        return (a >= b) ? (a - b) : 16'd0;
    endfunction

    logic [2:0]    r_state;
    logic [15:0]   r_fleet_x;
    logic [15:0]   r_fleet_y;
    logic          r_move_dir;
    logic          r_move_tick;
    logic          r_drop_tick;
    logic [N-1:0]  r_armed;
    logic          r_cleared;
    logic          r_landed;
    logic [15:0]   r_step_cnt;
    logic [15:0]   r_fire_cnt;
    logic          r_tick_pend;

    logic [NUM_COLS-1:0] w_col_alive;
    logic [CW-1:0]       w_lcol;
    logic [CW-1:0]       w_rcol;
    logic [16:0]         w_right_edge;
    logic [16:0]         w_left_edge;
    logic                w_edge_hit;
    logic [15:0]         w_period;
    logic                w_step_due;
    logic                w_fire_due;
    logic                w_fire_adv;
    logic                w_tick;
    logic                w_alive_any;
    logic [N-1:0]        w_grant;

    // Column occupancy: a column counts if any row in it is alive.
    for (genvar c = 0; c < int'(NUM_COLS); c++) begin : g_col
        logic [NUM_ROWS-1:0] w_col_bits;
        for (genvar r = 0; r < int'(NUM_ROWS); r++) begin : g_row
            assign w_col_bits[r] = i_alive_mask[r*NUM_COLS + c];
        end
        assign w_col_alive[c] = |w_col_bits;
    end

    always_comb begin
        w_lcol = '0;
        w_rcol = '0;
        for (int c = int'(NUM_COLS) - 1; c >= 0; c--) begin
            if (|(w_col_alive & (NUM_COLS'(1) << c))) w_lcol = CW'(c);
        end
        for (int c = 0; c < int'(NUM_COLS); c++) begin
            if (|(w_col_alive & (NUM_COLS'(1) << c))) w_rcol = CW'(c);
        end
    end

    // 17-bit edge sums so a fleet near the right of a 16-bit range cannot alias past the bound.
    assign w_right_edge = {1'b0, r_fleet_x} + 17'(w_rcol) * {1'b0, COL_PITCH}
                        + {1'b0, SPRITE_W} + {1'b0, STEP_X};
    assign w_left_edge  = {1'b0, r_fleet_x} + 17'(w_lcol) * {1'b0, COL_PITCH};
    assign w_edge_hit   = r_move_dir ? (w_right_edge > {1'b0, RIGHT_BOUND})
                                     : (w_left_edge < ({1'b0, LEFT_BOUND} + {1'b0, STEP_X}));

`ifdef ALIEN_FLEET_SPEEDUP_EN
    function automatic logic [15:0] floor_period(input logic [15:0] dead);
        logic [15:0] diff;
        diff = (BASE_PERIOD > dead) ? (BASE_PERIOD - dead) : 16'd0;
        return (diff > MIN_PERIOD) ? diff : MIN_PERIOD;
    endfunction

    logic [15:0] w_alive_cnt;
    assign w_alive_cnt = 16'($countones(i_alive_mask));
    assign w_period    = floor_period(16'(N) - w_alive_cnt);
`else
    assign w_period = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
`endif

    assign w_alive_any = |i_alive_mask;
    assign w_tick      = i_frame_tick | r_tick_pend;
    assign w_step_due  = ({1'b0, r_step_cnt} + 17'd1) >= {1'b0, w_period};
    assign w_fire_due  = (r_fire_cnt == (FIRE_PERIOD - 16'd1));
    assign w_fire_adv  = !i_start && (r_state == ST_MARCH) && w_alive_any && w_tick
                      && w_fire_due && !i_shot_busy;

    fleet_rr_arbiter #(.N(N)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_alive_mask),
        .i_advance (w_fire_adv),
        .o_grant   (w_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_fleet_x   <= START_X;
            r_fleet_y   <= START_Y;
            r_move_dir  <= 1'b1;
            r_move_tick <= 1'b0;
            r_drop_tick <= 1'b0;
            r_armed     <= '0;
            r_cleared   <= 1'b0;
            r_landed    <= 1'b0;
            r_step_cnt  <= '0;
            r_fire_cnt  <= '0;
            r_tick_pend <= 1'b0;
        end else begin
            r_move_tick <= 1'b0;
            r_drop_tick <= 1'b0;
            r_armed     <= '0;
            if (i_start) begin
                r_state     <= ST_MARCH;
                r_fleet_x   <= START_X;
                r_fleet_y   <= START_Y;
                r_move_dir  <= 1'b1;
                r_cleared   <= 1'b0;
                r_landed    <= 1'b0;
                r_step_cnt  <= '0;
                r_fire_cnt  <= '0;
                r_tick_pend <= 1'b0;
            end else begin
                case (r_state)
                    ST_MARCH: begin
                        r_tick_pend <= 1'b0;
                        if (!w_alive_any) begin
                            r_state   <= ST_CLEARED;
                            r_cleared <= 1'b1;
                        end else if (w_tick) begin
                            if (w_step_due) begin
                                r_step_cnt <= '0;
                                if (w_edge_hit) begin
                                    r_fleet_y   <= sat_add(r_fleet_y, STEP_Y);
                                    r_move_dir  <= ~r_move_dir;
                                    r_drop_tick <= 1'b1;
                                    r_state     <= ST_DROP;
                                end else begin
                                    r_fleet_x   <= r_move_dir ? sat_add(r_fleet_x, STEP_X)
                                                              : sat_sub(r_fleet_x, STEP_X);
                                    r_move_tick <= 1'b1;
                                end
                            end else begin
                                r_step_cnt <= r_step_cnt + 16'd1;
                            end
                            // Fire counter parks at its last value while a shot is in flight.
                            if (w_fire_due) begin
                                if (!i_shot_busy) begin
                                    r_fire_cnt <= '0;
                                    r_armed    <= w_grant;
                                end
                            end else begin
                                r_fire_cnt <= r_fire_cnt + 16'd1;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (i_frame_tick) r_tick_pend <= 1'b1;
                        if (r_fleet_y >= LAND_Y) begin
                            r_state  <= ST_LANDED;
                            r_landed <= 1'b1;
                        end else begin
                            r_state <= ST_MARCH;
                        end
                    end
                    ST_IDLE, ST_CLEARED, ST_LANDED: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_move_tick = r_move_tick;
    assign o_drop_tick = r_drop_tick;
    assign o_move_dir  = r_move_dir;
    assign o_fleet_x   = r_fleet_x;
    assign o_fleet_y   = r_fleet_y;
    assign o_armed     = r_armed;
    assign o_cleared   = r_cleared;
    assign o_landed    = r_landed;

endmodule

// File: tb/tb_alien_fleet_controller.sv
// Directed bench for alien_fleet_controller; a second instance starts near the floor for the landing case.
module tb_alien_fleet_controller;

`ifdef ALIEN_FLEET_SPEEDUP_EN
    localparam int EXP_PER = 2;
`else
    localparam int EXP_PER = 30;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        frame_tick;
    logic [31:0] alive;
    logic        shot_busy;

    logic        move_tick, drop_tick, move_dir, cleared, landed;
    logic [15:0] fleet_x, fleet_y;
    logic [31:0] armed;
    logic        move_tick2, drop_tick2, move_dir2, cleared2, landed2;
    logic [15:0] fleet_x2, fleet_y2;
    logic [31:0] armed2;

    int n_checks;
    int n_err;

    always #5 clk = ~clk;

    alien_fleet_controller dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_frame_tick(frame_tick),
        .i_alive_mask(alive), .i_shot_busy(shot_busy),
        .o_move_tick(move_tick), .o_drop_tick(drop_tick), .o_move_dir(move_dir),
        .o_fleet_x(fleet_x), .o_fleet_y(fleet_y), .o_armed(armed),
        .o_cleared(cleared), .o_landed(landed)
    );

    alien_fleet_controller #(.START_X(16'd428), .START_Y(16'd392)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_frame_tick(frame_tick),
        .i_alive_mask(alive), .i_shot_busy(shot_busy),
        .o_move_tick(move_tick2), .o_drop_tick(drop_tick2), .o_move_dir(move_dir2),
        .o_fleet_x(fleet_x2), .o_fleet_y(fleet_y2), .o_armed(armed2),
        .o_cleared(cleared2), .o_landed(landed2)
    );

    // Event monitor, sampled on the falling edge.
    int   mv_cnt = 0, dr_cnt = 0, gr_cnt = 0, gr_last = -1, mv2_cnt = 0, dr2_cnt = 0;
    logic both_seen = 1'b0, onehot_bad = 1'b0;

    always @(negedge clk) begin
        if (move_tick)  mv_cnt  <= mv_cnt + 1;
        if (drop_tick)  dr_cnt  <= dr_cnt + 1;
        if (move_tick2) mv2_cnt <= mv2_cnt + 1;
        if (drop_tick2) dr2_cnt <= dr2_cnt + 1;
        if ((move_tick && drop_tick) || (move_tick2 && drop_tick2)) both_seen <= 1'b1;
        if (armed != 32'd0) begin
            gr_cnt <= gr_cnt + 1;
            if ($countones(armed) != 1) onehot_bad <= 1'b1;
            for (int i = 0; i < 32; i++) begin
                if (((armed >> i) & 32'd1) != 32'd0) gr_last <= i;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_mv, base_dr, base_gr, base_mv2, base_dr2;
        n_checks   = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        frame_tick = 1'b0;
        alive      = 32'hFFFF_FFFF;
        shot_busy  = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_x", fleet_x, 32);
        check("rst_y", fleet_y, 40);
        check("rst_dir", move_dir, 1);
        check("rst_move", move_tick, 0);
        check("rst_drop", drop_tick, 0);
        check("rst_armed", armed, 0);
        check("rst_cleared", cleared, 0);
        check("rst_landed", landed, 0);

        rst_n = 1'b1;
        @(negedge clk);
        frame();
        check("idle_no_move", mv_cnt, 0);

        // Full fleet: first step after 30 ticks
        pulse_start();
        repeat (29) frame();
        check("pre_move_cnt", mv_cnt, 0);
        check("pre_move_x", fleet_x, 32);
        frame();
        check("first_move_cnt", mv_cnt, 1);
        check("first_move_x", fleet_x, 36);

        // March to the right edge (col 7): 100 steps to x=432, then drop
        n = 0;
        while (dr_cnt == 0 && n < 3100) begin frame(); n++; end
        check("drop_ticks", n, 3000);
        check("drop_x", fleet_x, 432);
        check("drop_y", fleet_y, 48);
        check("drop_dir", move_dir, 0);
        check("drop_moves", mv_cnt, 100);
        repeat (30) frame();
        check("left_step_x", fleet_x, 428);
        check("left_step_moves", mv_cnt, 101);

        // Column 7 dead: right edge from col 6, drop at x=456
        alive = 32'h7F7F_7F7F;
        pulse_start();
        check("restart_x", fleet_x, 32);
        check("restart_dir", move_dir, 1);
        base_mv = mv_cnt;
        base_dr = dr_cnt;
        n = 0;
        while (dr_cnt == base_dr && n < 4000) begin frame(); n++; end
        check("c7_drop_seen", dr_cnt - base_dr, 1);
        check("c7_drop_x", fleet_x, 456);
        check("c7_moves", mv_cnt - base_mv, 106);
        check("c7_drop_y", fleet_y, 48);

        // 4 of 32 alive: step period
        alive = 32'h0000_000F;
        pulse_start();
        base_mv = mv_cnt;
        n = 0;
        while (mv_cnt == base_mv && n < 40) begin frame(); n++; end
        check("period_ticks", n, EXP_PER);
        check("period_x", fleet_x, 36);

        // Fire arbitration between aliens 3 and 10
        alive = 32'h0000_0408;
        pulse_start();
        shot_busy = 1'b0;
        base_gr = gr_cnt;
        repeat (45) frame();
        check("grant1_cnt", gr_cnt - base_gr, 1);
        check("grant1_idx", gr_last, 3);
        repeat (45) frame();
        check("grant2_cnt", gr_cnt - base_gr, 2);
        check("grant2_idx", gr_last, 10);
        repeat (45) frame();
        check("grant3_cnt", gr_cnt - base_gr, 3);
        check("grant3_idx", gr_last, 3);
        shot_busy = 1'b1;
        repeat (60) frame();
        check("busy_no_grant", gr_cnt - base_gr, 3);
        shot_busy = 1'b0;
        frame();
        check("busy_release_cnt", gr_cnt - base_gr, 4);
        check("busy_release_idx", gr_last, 10);
        check("armed_onehot", onehot_bad, 0);

        // Landing on the second instance (starts at x=428, y=392)
        shot_busy = 1'b1;
        alive = 32'hFFFF_FFFF;
        pulse_start();
        base_dr2 = dr2_cnt;
        n = 0;
        while (dr2_cnt == base_dr2 && n < 100) begin frame(); n++; end
        check("land_ticks", n, 60);
        check("land_y", fleet_y2, 400);
        check("land_flag", landed2, 1);
        check("land_dir", move_dir2, 0);
        base_mv2 = mv2_cnt;
        base_dr2 = dr2_cnt;
        repeat (60) frame();
        check("landed_no_move", mv2_cnt - base_mv2, 0);
        check("landed_no_drop", dr2_cnt - base_dr2, 0);
        check("landed_x_hold", fleet_x2, 432);

        pulse_start();
        check("reload_x2", fleet_x2, 428);
        check("reload_y2", fleet_y2, 392);
        check("reload_landed2", landed2, 0);
        check("reload_x", fleet_x, 32);
        check("reload_y", fleet_y, 40);
        check("reload_dir", move_dir, 1);

        alive = 32'd0;
        repeat (2) @(negedge clk);
        check("cleared", cleared, 1);
        check("cleared2", cleared2, 1);
        check("cleared_not_landed", landed, 0);
        check("never_both_pulses", both_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
